main_control_fsm: RTL

Multi-cycle main control unit for the 32-bit MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states. Every cycle it drives the datapath strobes and the 3-bit `alu_op` field consumed by `alu_control`. Memory accesses use a `mem_ready` handshake, so instruction and data memories may insert wait states.

---
 rtl/ctrl_pkg.sv | 74 +++++++
 rtl/main_control_fsm.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, ALUop
// codes, FSM states and the datapath mux select codes.
package ctrl_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SUBI  = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // funct code of jr within RTYPE
  localparam logic [5:0] FUNCT_JR = 6'h08;

  // ALUop codes shared with alu_control
  localparam logic [2:0] ALUOP_AND   = 3'b000;
  localparam logic [2:0] ALUOP_OR    = 3'b001;
  localparam logic [2:0] ALUOP_SLT   = 3'b010;
  localparam logic [2:0] ALUOP_ADD   = 3'b101;
  localparam logic [2:0] ALUOP_SUB   = 3'b110;
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;

  // alu_src_b select codes
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // pc_source select codes
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG_A  = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC    = 4'd2,
    S_ALU_WB  = 4'd3,
    S_ADDR    = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_LOAD_WB = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9
  } state_e;

  // Immediate-form ALU instructions routed through EXEC
  function automatic logic is_imm_alu(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_SLTI) ||
           (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  // ALUop used in EXEC for a given opcode
  function automatic logic [2:0] exec_alu_op(input logic [5:0] op);
    case (op)
      OP_RTYPE: return ALUOP_RTYPE;
      OP_ANDI:  return ALUOP_AND;
      OP_ORI:   return ALUOP_OR;
      OP_SLTI:  return ALUOP_SLT;
      OP_SUBI:  return ALUOP_SUB;
      default:  return ALUOP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/main_control_fsm.sv
// Multi-cycle main control unit: sequences fetch/decode/execute/memory/
// write-back and decodes the datapath strobes from the current state.
module main_control_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_byte,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal
);

  state_e r_state;
  state_e w_next_state;
  logic   w_is_rtype;
  logic   w_is_jr;

  assign w_is_rtype = (opcode == OP_RTYPE);
  assign w_is_jr    = w_is_rtype && (funct == FUNCT_JR);

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge values regardless of block ordering.
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assigned first so no path through the case infers a latch.
    w_next_state = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        if (w_is_jr || opcode == OP_J)                 w_next_state = S_JUMP;
        else if (w_is_rtype || is_imm_alu(opcode))     w_next_state = S_EXEC;
        else if (opcode == OP_LB || opcode == OP_LW ||
                 opcode == OP_SB || opcode == OP_SW)   w_next_state = S_ADDR;
        else if (opcode == OP_BEQ || opcode == OP_BNE) w_next_state = S_BRANCH;
        else                                           w_next_state = S_FETCH;
      end
      S_EXEC:   w_next_state = S_ALU_WB;
      S_ALU_WB: w_next_state = S_FETCH;
      S_ADDR:   w_next_state = (opcode == OP_LB || opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) w_next_state = S_LOAD_WB;
      S_MEM_WR: if (mem_ready) w_next_state = S_FETCH;
      S_LOAD_WB, S_BRANCH, S_JUMP: w_next_state = S_FETCH;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // Output decode; everything forced low while reset is asserted
  always_comb begin
    alu_op     = ALUOP_AND;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_write   = 1'b0;
    pc_source  = PCSRC_ALU;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_byte   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALUOP_ADD;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH;
          alu_op    = ALUOP_ADD;
          if (!(w_is_rtype || is_imm_alu(opcode) || opcode == OP_J ||
                opcode == OP_BEQ || opcode == OP_BNE ||
                opcode == OP_LB || opcode == OP_LW ||
                opcode == OP_SB || opcode == OP_SW)) begin
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = w_is_rtype ? SRCB_REG : SRCB_IMM;
          alu_op    = exec_alu_op(opcode);
        end
        S_ALU_WB: begin
          reg_write  = 1'b1;
          reg_dst    = w_is_rtype;
          instr_done = 1'b1;
        end
        S_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_ADD;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          mem_byte = (opcode == OP_LB);
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          mem_byte   = (opcode == OP_SB);
          instr_done = mem_ready;
        end
        S_LOAD_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_REG;
          alu_op     = ALUOP_SUB;
          pc_source  = PCSRC_ALUOUT;
          pc_write   = (opcode == OP_BNE) ? !zero : zero;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = w_is_jr ? PCSRC_REG_A : PCSRC_JUMP;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
